// File: rtl/jtopl_lfo.sv
// jtopl_lfo: low-frequency oscillator for the OPL core.
//   Produces the vibrato phase word and the tremolo attenuation value.
//   State advances once per output sample, in the operator clock-enable
//   domain (cenop). Samples are counted only when cenop and zero are both high.
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset
//   cenop    operator clock enable; all state advances only when high
//   zero     sample-start strobe, qualified by cenop
//   lfo_rst  synchronous LFO clear (test register), qualified by cenop
//   am_dep   tremolo depth: 1 = 4.8 dB (0..26), 0 = 1 dB (0..6)
//   lfo_mod  vibrato phase word (registered counter)
//   am       tremolo attenuation value (registered)
module jtopl_lfo #(
    parameter int unsigned PRESC_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    input  logic       zero,
    input  logic       lfo_rst,
    input  logic       am_dep,
    output logic [6:0] lfo_mod,
    output logic [4:0] am
);

    localparam int unsigned MOD_W  = 7;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned AM_W   = 5;
    localparam int unsigned TRI_W  = 7;
    localparam logic [CNT_W-1:0] AM_LAST = CNT_W'(209);
    localparam logic [CNT_W-1:0] AM_HALF = CNT_W'(104);

    logic [PRESC_W-1:0] r_presc;
    logic [MOD_W-1:0]   r_lfo_mod;
    logic [CNT_W-1:0]   r_am_cnt;
    logic [AM_W-1:0]    r_am;

    logic               w_tick;
    logic               w_step;
    logic [CNT_W-1:0]   w_am_cnt_inc;
    logic [TRI_W-1:0]   w_tri;
    logic [AM_W-1:0]    w_am_nxt;

    // One tick per sample; a step happens on the tick that wraps the prescaler.
    assign w_tick = cenop & zero;
    assign w_step = w_tick & (&r_presc);

    // Tremolo position wraps after 209 so the triangle is 210 steps long.
    assign w_am_cnt_inc = (r_am_cnt == AM_LAST) ? '0 : r_am_cnt + CNT_W'(1);

    // Triangle: rises 0..104, then mirrors back down (105 -> 104 ... 209 -> 0).
    always_comb begin
        w_tri = '0;
        if (r_am_cnt <= AM_HALF) begin
            w_tri = r_am_cnt[TRI_W-1:0];
        end else begin
            w_tri = TRI_W'(AM_LAST - r_am_cnt);
        end
    end

    // Depth select scales the triangle down to the final attenuation range.
    always_comb begin
        w_am_nxt = '0;
        if (am_dep) begin
            w_am_nxt = AM_W'(w_tri >> 2);
        end else begin
            w_am_nxt = AM_W'(w_tri >> 4);
        end
    end

    // Sample prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (cenop) begin
            if (lfo_rst) begin
                r_presc <= '0;
            end else if (w_tick) begin
                r_presc <= r_presc + PRESC_W'(1);
            end
        end
    end

    // Vibrato counter, free running over 0..127.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfo_mod <= '0;
        end else if (cenop) begin
            if (lfo_rst) begin
                r_lfo_mod <= '0;
            end else if (w_step) begin
                r_lfo_mod <= r_lfo_mod + MOD_W'(1);
            end
        end
    end

    // Tremolo position, 0..209.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_am_cnt <= '0;
        end else if (cenop) begin
            if (lfo_rst) begin
                r_am_cnt <= '0;
            end else if (w_step) begin
                r_am_cnt <= w_am_cnt_inc;
            end
        end
    end

    // Tremolo output refreshed every cenop cycle from the current position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_am <= '0;
        end else if (cenop) begin
            if (lfo_rst) begin
                r_am <= '0;
            end else begin
                r_am <= w_am_nxt;
            end
        end
    end

    assign lfo_mod = r_lfo_mod;
    assign am      = r_am;

    // The tremolo position must never leave its 210-step range.
    a_am_cnt_range: assert property (@(posedge clk) disable iff (rst) r_am_cnt <= AM_LAST)
        else $error("am_cnt out of range: %0d", r_am_cnt);

endmodule

// File: tb/tb_jtopl_lfo.sv
// Self-checking bench for jtopl_lfo: driver pushes expected outputs from a
// sample-count model into a queue; a monitor pops and compares each cycle.
module tb_jtopl_lfo;

    localparam int unsigned PRESC_W = 6;
    localparam int STEP = 1 << PRESC_W;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cenop = 1'b0;
    logic       zero = 1'b0;
    logic       lfo_rst = 1'b0;
    logic       am_dep = 1'b0;
    logic [6:0] lfo_mod;
    logic [4:0] am;

    typedef struct {
        int     cyc;
        logic [6:0] mod;
        logic [4:0] am;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: samples counted since the last clear, and the expected am.
    int         ticks = 0;
    logic [4:0] m_am  = '0;

    jtopl_lfo #(.PRESC_W(PRESC_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .cenop   (cenop),
        .zero    (zero),
        .lfo_rst (lfo_rst),
        .am_dep  (am_dep),
        .lfo_mod (lfo_mod),
        .am      (am)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] shape(input int t, input bit dep);
        int pos;
        int tri_v;
        pos   = (t / STEP) % 210;
        tri_v = (pos <= 104) ? pos : 209 - pos;
        return dep ? 5'(tri_v / 4) : 5'(tri_v / 16);
    endfunction

    function automatic logic [6:0] exp_mod(input int t);
        return 7'((t / STEP) % 128);
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // Drive one clock cycle and record the outputs expected after its edge.
    task automatic cycle(input bit r, input bit c, input bit z, input bit l, input bit d);
        exp_t e;
        @(negedge clk);
        rst = r; cenop = c; zero = z; lfo_rst = l; am_dep = d;
        if (r) begin
            ticks = 0;
            m_am  = '0;
        end else if (c) begin
            if (l) begin
                ticks = 0;
                m_am  = '0;
            end else begin
                m_am = shape(ticks, d);
                if (z) ticks++;
            end
        end
        e.cyc = cyc;
        e.mod = exp_mod(ticks);
        e.am  = m_am;
        q.push_back(e);
        @(posedge clk);
        cyc++;
    endtask

    // Monitor: outputs are valid every cycle; compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("lfo_mod", int'(lfo_mod), int'(e.mod));
                check("am", int'(am), int'(e.am));
            end
        end
    end

    initial begin
        bit d;
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1);

        // Long run through full vibrato and tremolo periods.
        for (int i = 0; i < 13500; i++) begin
            if (ticks < 6800)      d = 1'b1;
            else if (ticks < 7000) d = 1'b0;
            else                   d = 1'($urandom_range(0, 1));
            cycle(0, 1, 1, 0, d);
        end

        // zero pulses with cenop low must be ignored.
        for (int i = 0; i < 1000; i++)
            cycle(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // lfo_rst coinciding with a step event.
        for (int i = 0; i < STEP && (ticks % STEP) != STEP - 1; i++) cycle(0, 1, 1, 0, 1);
        check("presc_at_wrap", ticks % STEP, STEP - 1);
        cycle(0, 1, 1, 1, 1);
        cycle(0, 1, 1, 1, 1);
        cycle(0, 1, 0, 1, 0);

        // Randomized enables, strobes, depth and occasional clears.
        for (int i = 0; i < 3000; i++)
            cycle(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)));

        // Count to lfo_mod = 0x35, then reset asynchronously between edges.
        cycle(0, 1, 1, 1, 1);
        for (int i = 0; i < 53 * STEP; i++) cycle(0, 1, 1, 0, 1);
        check("mid_count_model", int'(exp_mod(ticks)), 8'h35);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_mod", int'(lfo_mod), 0);
        check("async_rst_am", int'(am), 0);
        cycle(1, 1, 1, 0, 1);
        cycle(1, 1, 1, 0, 1);
        for (int i = 0; i < STEP + 2; i++) cycle(0, 1, 1, 0, 1);

        @(posedge clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule
